// File: rtl/div_seq_pkg.sv
// Shared constants and state encoding for the EX-stage DIV/DIVU sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam int          DoubleRegBus = 64;

endpackage

// File: rtl/div_seq.sv
// div_seq: radix-2 shift-subtract DIV/DIVU sequencer; ready 33 edges after start (2 for a zero divisor).
// Backpressure: result and ready are held in END for as long as EX keeps start high.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // The compare is done on DATA_W+1 bits so a 2^31 magnitude divisor never overflows.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] r,
                                                   input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W:0] r_sh;
    r_sh = {r, q[DATA_W-1]};
    if (r_sh >= {1'b0, d})
      return {r_sh[DATA_W-1:0] - d, q[DATA_W-2:0], 1'b1};
    else
      return {r_sh[DATA_W-1:0], q[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
            quo_d     = magnitude(opdata1_i, signed_div_i);
            dvs_d     = magnitude(opdata2_i, signed_div_i);
            rem_d     = '0;
          end
        end
      end

      // Ready is raised by END itself, one edge after the zero result is registered.
      DivByZero: begin
        result_d = '0;
        state_d  = annul_i ? DivFree : DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = {neg_rem_q ? (~rem_q + 1'b1) : rem_q,
                      neg_quo_q ? (~quo_q + 1'b1) : quo_q};
        end else begin
          {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
          cnt_d          = cnt_q + CNT_W'(1);
        end
      end

      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          ready_d = DivResultReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: table-driven divisions plus hand-written annul/reset/hold sequences.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_chk;
  int n_fail;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation and waits for ready; lat is the index of the edge after which ready was seen (E0 = 0).
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int lat);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    lat        = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_chk(input string name);
    start = 1'b0;
    step();
    chk({name, " release ready"}, 64'(ready), 64'd0);
    chk({name, " release result"}, result, 64'd0);
  endtask

  initial begin
    int lat;
    int hits;
    logic [63:0] held;

    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{"u100/7",        1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, 33};
    vecs[1]  = '{"s-7/2",         1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2]  = '{"s80000000/-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 33};
    vecs[3]  = '{"u1234/0",       1'b0, 32'h00001234,  32'h00000000,  32'h00000000, 32'h00000000, 2};
    vecs[4]  = '{"uFFFFFFFF/1",   1'b0, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 32'h00000000, 33};
    vecs[5]  = '{"s7/-2",         1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 33};
    vecs[6]  = '{"s-7/-2",        1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'h00000003, 32'hFFFFFFFF, 33};
    vecs[7]  = '{"uFFFFFFF9/2",   1'b0, 32'hFFFFFFF9,  32'h00000002,  32'h7FFFFFFC, 32'h00000001, 33};
    vecs[8]  = '{"u5/10",         1'b0, 32'd5,         32'd10,        32'h00000000, 32'h00000005, 33};
    vecs[9]  = '{"s-1/0",         1'b1, 32'hFFFFFFFF,  32'h00000000,  32'h00000000, 32'h00000000, 2};
    vecs[10] = '{"uFFFFFFFF/80000000", 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 33};

    rst        = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    step();
    step();
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b1;
    step();

    foreach (vecs[k]) begin
      run_op(vecs[k].sgn, vecs[k].a, vecs[k].b, lat);
      chk({vecs[k].name, " latency"}, 64'(lat), 64'(vecs[k].lat));
      chk({vecs[k].name, " result"}, result, {vecs[k].r, vecs[k].q});
      release_chk(vecs[k].name);
    end

    // Annul pulsed on E10 abandons the operation; start is dropped with it.
    signed_div = 1'b0;
    opdata1    = 32'h100;
    opdata2    = 32'd3;
    start      = 1'b1;
    for (int i = 0; i < 10; i++) step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    start = 1'b0;
    hits  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) hits++;
    end
    chk("annul mid-ON ready count", 64'(hits), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, lat);
    chk("9/3 after annul latency", 64'(lat), 64'd33);
    chk("9/3 after annul result", result, {32'd0, 32'd3});
    release_chk("9/3 after annul");

    // Annul takes priority over start while in FREE.
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd5;
    start      = 1'b1;
    annul      = 1'b1;
    hits       = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) hits++;
    end
    chk("annul in FREE ready count", 64'(hits), 64'd0);
    annul = 1'b0;
    run_op(1'b0, 32'd50, 32'd5, lat);
    chk("50/5 after FREE annul latency", 64'(lat), 64'd33);
    chk("50/5 after FREE annul result", result, {32'd0, 32'd10});
    release_chk("50/5");

    // Annul during BYZERO returns to FREE without ever raising ready.
    opdata1 = 32'd1;
    opdata2 = 32'd0;
    start   = 1'b1;
    step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    start = 1'b0;
    hits  = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready) hits++;
    end
    chk("annul in BYZERO ready count", 64'(hits), 64'd0);

    // Operands scrambled during ON, then start held in END for 5 edges.
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    start      = 1'b1;
    lat        = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 4) begin
        signed_div = 1'b1;
        opdata1    = 32'hDEAD_BEEF;
        opdata2    = 32'h0;
      end
      if (ready) begin
        lat = i;
        break;
      end
    end
    chk("operand change latency", 64'(lat), 64'd33);
    chk("operand change result", result, {32'd6, 32'd142});
    held = result;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("END hold %0d ready", i), 64'(ready), 64'd1);
      chk($sformatf("END hold %0d result", i), result, held);
    end
    annul = 1'b1;
    step();
    chk("annul in END ready", 64'(ready), 64'd0);
    chk("annul in END result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    step();

    // Asynchronous reset mid-ON, then a normal operation.
    signed_div = 1'b0;
    opdata1    = 32'd77;
    opdata2    = 32'd4;
    start      = 1'b1;
    for (int i = 0; i < 15; i++) step();
    #2 rst = 1'b0;
    #1;
    chk("async rst mid-ON ready", 64'(ready), 64'd0);
    chk("async rst mid-ON result", result, 64'd0);
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_op(1'b0, 32'd77, 32'd4, lat);
    chk("77/4 after reset latency", 64'(lat), 64'd33);
    chk("77/4 after reset result", result, {32'd1, 32'd19});

    // Asynchronous reset while the result is held in END.
    #2 rst = 1'b0;
    #1;
    chk("async rst in END ready", 64'(ready), 64'd0);
    chk("async rst in END result", result, 64'd0);
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, lat);
    chk("-100/7 after reset latency", 64'(lat), 64'd33);
    chk("-100/7 after reset result", result, {32'hFFFFFFFE, 32'hFFFFFFF2});
    release_chk("-100/7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle radix-2 shift-subtract divider sequencer serving the EX stage's DIV/DIVU requests.
- EX holds start_i and operands for the whole operation and stalls the pipeline until ready_o. It then writes result_o to HI/LO and drops start_i.
- Handles signed/unsigned operands, divide-by-zero, and annulment (flush) mid-operation.
- Sits between EX and EX/MEM, clocked with the pipeline.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled at start.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- start_i  in  1  DivStart request level, held high by EX until it consumes the result.
- annul_i  in  1  flush: abandon the current operation.
- result_o  out  2*DATA_W  {remainder, quotient} = {HI, LO}.
- ready_o  out  1  DivResultReady when result_o is valid.

Behaviour:
- Reset (rst low, asynchronous): state = FREE, cnt = 0, ready_o = 0, result_o = 0, working registers = 0. Takes effect immediately, including mid-operation.
- States: FREE, BYZERO, ON, END, encoded 2 bits.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON; cnt = 0; latch sign flags.
  - On entry to ON: latch |opdata1_i| and |opdata2_i| (absolute values only when signed_div_i=1 and the MSB is set), and clear the partial remainder.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: next edge -> END with result_o = 0 and ready_o = 1. annul_i=1 -> FREE instead.
- ON, one iteration per edge:
  - Shift {R, Q} left by 1. Trial = R_shifted - D (33-bit).
  - If the trial is non-negative: R = trial, Q[0] = 1. Else Q[0] = 0.
  - cnt increments each iteration.
  - At the edge where cnt == DATA_W (after 32 iterations), go to END.
  - On that edge register the corrected result:
    - quotient negated when signed and the operand signs differ;
    - remainder negated when signed and the dividend is negative.
  - Set ready_o = 1 on the same edge.
  - annul_i=1 at any ON edge -> FREE, ready_o = 0, result discarded.
- Latency:
  - Call the edge that samples start in FREE E0.
  - ready_o is high after E33 for a nonzero divisor.
  - ready_o is high after E2 for a zero divisor.
- END:
  - ready_o = 1; result_o held stable.
  - start_i=0 or annul_i=1 -> FREE with ready_o = 0 and result_o = 0 on that edge.
  - start_i still high -> remain in END. Never restart without start_i first going low.
- Operand inputs are ignored outside the FREE->ON/BYZERO edge; changes during ON do not affect the result.
- Signed boundary: 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. The 33-bit trial makes the magnitude 2^31 safe.
- annul_i has priority over start_i in every state.

Decomposition:
- Constants belong in the shared defines file:
  - DivFree/DivByZero/DivOn/DivEnd;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - ZeroWord;
  - DoubleRegBus.
- Single module; no sub-module is required.
- The iteration step may be written as a local function.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held -> ready_o rises after E33; result_o = {0x00000002, 0x0000000E}. Release start -> ready_o = 0, result_o = 0 next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Divisor 0 (opdata1=0x1234) -> ready_o after E2, result_o = 0. Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at E10 of an operation -> FREE, ready_o never asserts. Then start 9/3 -> {0, 3} after 33 cycles.
- rst driven low asynchronously mid-ON (between edges) -> ready_o = 0 and result_o = 0 immediately. After release, a new start completes normally.
- start held in END for 5 cycles -> ready_o and result_o stable throughout, no re-execution. Operands changed during ON -> result unaffected.
